// File: rtl/stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : stream_serializer
// Purpose  : Splits a wide input word (DATA_WIDTH*RATIO bits) into RATIO
//            output beats of DATA_WIDTH bits, least-significant beat first.
//            A one-word holding buffer lets the next word be accepted while
//            the current one is still being sent. This gives one beat per
//            cycle with no bubble between words.
// Ports    : i_clock        - sole clock, rising edge
//            i_aresetn      - synchronous active-low reset
//            i_clear        - synchronous clear, same effect as reset
//            i_data         - wide input word
//            i_input_valid  - input word valid
//            o_input_ready  - block can take a word (registered)
//            o_data         - current output beat
//            o_output_valid - output beat valid (registered)
//            i_output_ready - downstream ready
//            o_last         - current beat is the final beat of its word
//            o_accept       - input handshake this cycle
//            o_transmit     - output handshake this cycle
// Revision : 1.0 - initial release
// ============================================================================
module stream_serializer #(
  parameter int DATA_WIDTH = 32,
  parameter int RATIO      = 4
) (
  input  logic                          i_clock,
  input  logic                          i_aresetn,
  input  logic                          i_clear,
  input  logic [DATA_WIDTH*RATIO-1:0]   i_data,
  input  logic                          i_input_valid,
  output logic                          o_input_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic                          o_output_valid,
  input  logic                          i_output_ready,
  output logic                          o_last,
  output logic                          o_accept,
  output logic                          o_transmit
);

  localparam int c_WORD_W = DATA_WIDTH * RATIO;
  localparam int c_CNT_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(RATIO - 1);

  localparam logic [1:0] c_EMPTY  = 2'd0;
  localparam logic [1:0] c_ACTIVE = 2'd1;
  localparam logic [1:0] c_FULL   = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [c_CNT_W-1:0]  cnt_q, cnt_d;
  logic [c_WORD_W-1:0] word_q, word_d;
  logic [c_WORD_W-1:0] buf_q, buf_d;
  logic                in_ready_q;
  logic                out_valid_q;

  logic                w_flush;
  logic                w_accept;
  logic                w_transmit;
  logic                w_is_last;
  logic [c_CNT_W-1:0]  w_cnt_inc;
  logic [DATA_WIDTH-1:0] w_beat;

  assign w_flush    = !i_aresetn || i_clear;
  assign w_accept   = i_input_valid && in_ready_q;
  assign w_transmit = out_valid_q && i_output_ready;
  assign w_is_last  = (cnt_q == c_CNT_LAST);

  // Explicit wrap keeps non-power-of-two ratios correct.
  assign w_cnt_inc  = w_is_last ? '0 : cnt_q + c_CNT_W'(1);

  // Beat select as a compare-mux so out-of-range counts for
  // non-power-of-two ratios select nothing instead of reading past the word.
  always_comb begin
    w_beat = '0;
    for (int b = 0; b < RATIO; b++) begin
      if (cnt_q == c_CNT_W'(b)) begin
        w_beat = word_q[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    buf_d   = buf_q;
    case (state_q)
      c_EMPTY: begin
        if (w_accept) begin
          word_d  = i_data;
          cnt_d   = '0;
          state_d = c_ACTIVE;
        end
      end
      c_ACTIVE: begin
        if (w_transmit && !w_is_last) begin
          cnt_d = w_cnt_inc;
          if (w_accept) begin
            buf_d   = i_data;
            state_d = c_FULL;
          end
        end else if (w_transmit) begin
          // Last beat leaves: a word arriving now goes straight to the
          // word register so the next beat follows without a gap.
          if (w_accept) begin
            word_d  = i_data;
            cnt_d   = '0;
            state_d = c_ACTIVE;
          end else begin
            state_d = c_EMPTY;
          end
        end else if (w_accept) begin
          buf_d   = i_data;
          state_d = c_FULL;
        end
      end
      c_FULL: begin
        if (w_transmit) begin
          if (!w_is_last) begin
            cnt_d = w_cnt_inc;
          end else begin
            word_d  = buf_q;
            cnt_d   = '0;
            state_d = c_ACTIVE;
          end
        end
      end
      default: begin
        state_d = c_EMPTY;
        cnt_d   = '0;
      end
    endcase

    if (w_flush) begin
      state_d = c_EMPTY;
      cnt_d   = '0;
      word_d  = '0;
      buf_d   = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    word_q  <= word_d;
    buf_q   <= buf_d;
    // Handshake flags come from the next state so that o_input_ready has
    // no combinational dependence on i_output_ready.
    if (w_flush) begin
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_d != c_FULL);
      out_valid_q <= (state_d != c_EMPTY);
    end
  end

  assign o_input_ready  = in_ready_q;
  assign o_output_valid = out_valid_q;
  assign o_data         = w_beat;
  assign o_last         = out_valid_q && w_is_last;
  assign o_accept       = w_accept;
  assign o_transmit     = w_transmit;

endmodule
`default_nettype wire

// File: tb/tb_stream_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_serializer
// Purpose  : Scoreboard bench for stream_serializer. The main instance
//            (8-bit beats, ratio 4) gets directed and random traffic. Each
//            accepted word is expanded into its expected beats in a queue,
//            and a monitor compares every presented beat and handshake flag
//            against an occupancy model. A second instance (ratio 3) gets a
//            short directed sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_serializer;

  localparam int DW = 8;
  localparam int R  = 4;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            clear = 1'b0;
  logic [DW*R-1:0] in_data = '0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic            in_ready, out_valid, last, accept, transmit;
  logic [DW-1:0]   out_data;

  logic            b_clear = 1'b0;
  logic [DW*3-1:0] b_in_data = '0;
  logic            b_in_valid = 1'b0;
  logic            b_out_ready = 1'b1;
  logic            b_in_ready, b_out_valid, b_last, b_accept, b_transmit;
  logic [DW-1:0]   b_out_data;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t exp_q[$];
  bit    stop_sink = 1'b0;

  always #5 clk = ~clk;

  stream_serializer #(.DATA_WIDTH(DW), .RATIO(R)) u_dut (
    .i_clock(clk), .i_aresetn(rstn), .i_clear(clear),
    .i_data(in_data), .i_input_valid(in_valid), .o_input_ready(in_ready),
    .o_data(out_data), .o_output_valid(out_valid), .i_output_ready(out_ready),
    .o_last(last), .o_accept(accept), .o_transmit(transmit)
  );

  stream_serializer #(.DATA_WIDTH(DW), .RATIO(3)) u_dut3 (
    .i_clock(clk), .i_aresetn(rstn), .i_clear(b_clear),
    .i_data(b_in_data), .i_input_valid(b_in_valid), .o_input_ready(b_in_ready),
    .o_data(b_out_data), .o_output_valid(b_out_valid), .i_output_ready(b_out_ready),
    .o_last(b_last), .o_accept(b_accept), .o_transmit(b_transmit)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one word and wait for the handshake; the expected beats are
  // queued in the cycle the handshake is seen.
  task automatic send_word(input logic [DW*R-1:0] w, input int gap);
    bit done = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = w;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        for (int b = 0; b < R; b++) exp_q.push_back('{d: w[b*DW +: DW], last: (b == R-1)});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got no ready expected ready within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  // Monitor: occupancy model (words held = 0/1/2) predicts the handshake
  // flags; the queue head predicts the presented beat.
  initial begin : monitor
    int    occ = 0;
    bit    post_reset = 1'b1;
    bit    exp_rdy, exp_vld, exp_acc, exp_tx;
    beat_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_rdy = !post_reset && (occ < 2);
      exp_vld = !post_reset && (occ > 0);
      exp_acc = in_valid && exp_rdy;
      exp_tx  = out_ready && exp_vld;
      chk("input_ready", 64'(in_ready), 64'(exp_rdy));
      chk("output_valid", 64'(out_valid), 64'(exp_vld));
      chk("accept", 64'(accept), 64'(exp_acc));
      chk("transmit", 64'(transmit), 64'(exp_tx));
      if (post_reset) begin
        chk("reset_data", 64'(out_data), 64'd0);
        chk("reset_last", 64'(last), 64'd0);
      end else if (exp_vld) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL scoreboard_empty: got beat %0h expected no beat", out_data);
        end else begin
          chk("beat_data", 64'(out_data), 64'(exp_q[0].d));
          chk("beat_last", 64'(last), 64'(exp_q[0].last));
        end
      end
      if (exp_tx && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.last) occ--;
      end
      if (exp_acc) occ++;
      if (!rstn || clear) begin
        exp_q.delete();
        occ = 0;
        post_reset = 1'b1;
      end else begin
        post_reset = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [DW*3-1:0] b_w1, b_w2;
    logic [DW*6-1:0] b_all;
    // Reset: held low for three cycles, monitor expects all-zero outputs.
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single word.
    send_word(32'h44332211, 0);
    repeat (6) @(posedge clk);
    #1;

    // Two words back to back.
    send_word(32'h44332211, 0);
    send_word(32'h88776655, 0);
    repeat (10) @(posedge clk);
    #1;

    // Backpressure on beat 0x22 for three cycles.
    fork
      send_word(32'h44332211, 0);
      begin
        bit seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
          @(negedge clk);
          if (out_valid && out_data == 8'h11) seen = 1'b1;
        end
        @(posedge clk); #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    // Clear while FULL: send 0x11 then stall on 0x22 and clear.
    out_ready = 1'b0;
    send_word(32'h44332211, 0);
    send_word(32'h88776655, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    // Random traffic with random backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) send_word($urandom, $urandom_range(0, 2));
        stop_sink = 1'b1;
      end
      begin
        while (!stop_sink) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("drain_remaining", 64'(exp_q.size()), 64'd0);

    // Ratio-3 instance: two words back to back.
    b_w1  = 24'h332211;
    b_w2  = 24'hCCBBAA;
    b_all = {b_w2, b_w1};
    @(posedge clk); #1;
    b_in_valid = 1'b1;
    b_in_data  = b_w1;
    @(posedge clk); #1;
    b_in_data  = b_w2;
    @(negedge clk);
    chk("r3_valid", 64'(b_out_valid), 64'd1);
    chk("r3_data", 64'(b_out_data), 64'(b_all[0 +: DW]));
    chk("r3_last", 64'(b_last), 64'd0);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      chk("r3_valid", 64'(b_out_valid), 64'd1);
      chk("r3_data", 64'(b_out_data), 64'(b_all[k*DW +: DW]));
      chk("r3_last", 64'(b_last), 64'((k % 3) == 2));
    end
    @(negedge clk);
    chk("r3_idle_valid", 64'(b_out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_serializer.md
STREAM_SERIALIZER -- requirements
Module: stream_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning output beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4, meaning output beats per input word; legal range RATIO >= 2, non-powers-of-two included.
REQ-003 i_clock  input  1  sole clock; all state updates on rising edge.
REQ-004 i_aresetn  input  1  reset, synchronous, active-low.
REQ-005 i_clear  input  1  synchronous clear, same effect as reset.
REQ-006 i_data  input  DATA_WIDTH*RATIO  wide input word.
REQ-007 i_input_valid  input  1  input word valid.
REQ-008 o_input_ready  output  1  block can take a word; registered.
REQ-009 o_data  output  DATA_WIDTH  current output beat.
REQ-010 o_output_valid  output  1  output beat valid; registered.
REQ-011 i_output_ready  input  1  downstream ready.
REQ-012 o_last  output  1  current beat is the final beat of its word.
REQ-013 o_accept  output  1  input handshake this cycle (i_input_valid && o_input_ready).
REQ-014 o_transmit  output  1  output handshake this cycle (o_output_valid && i_output_ready).

Function
REQ-015 Storage SHALL be a word register, a beat counter (0..RATIO-1, width max(1,$clog2(RATIO))), and a one-word holding buffer.
REQ-016 o_data SHALL be slice [cnt*DATA_WIDTH +: DATA_WIDTH] of the word register; beat 0 is the least-significant slice.
REQ-017 o_last SHALL equal o_output_valid && (cnt == RATIO-1).
REQ-018 States SHALL be EMPTY (no word), ACTIVE (word register loaded, buffer empty), FULL (word register and buffer both loaded).
REQ-019 EMPTY: on accept, load word register from i_data, cnt <= 0, go to ACTIVE; otherwise stay.
REQ-020 ACTIVE, transmit of a non-last beat: cnt <= cnt+1; if accept in the same cycle, buffer <= i_data and go to FULL.
REQ-021 ACTIVE, transmit of the last beat: with accept, load word register from i_data, cnt <= 0, stay ACTIVE; without accept, go to EMPTY.
REQ-022 ACTIVE, no transmit: with accept, buffer <= i_data and go to FULL; otherwise hold all state.
REQ-023 FULL: accept is impossible; transmit of a non-last beat increments cnt; transmit of the last beat loads word register from buffer, cnt <= 0, go to ACTIVE.
REQ-024 o_input_ready SHALL be registered as (next_state != FULL); o_output_valid SHALL be registered as (next_state != EMPTY); no combinational path from i_output_ready to o_input_ready.
REQ-025 Latency SHALL be one cycle: a word accepted at edge N presents beat 0 with o_output_valid=1 after edge N.
REQ-026 Throughput SHALL be one beat per cycle under continuous valid/ready, with no bubble between words.
REQ-027 While o_output_valid=1 and i_output_ready=0, o_data, o_last and cnt SHALL hold stable.
REQ-028 The counter SHALL wrap explicitly from RATIO-1 to 0, never via natural overflow.
REQ-029 Unreachable state encodings SHALL recover to EMPTY.

Reset
REQ-030 While i_aresetn=0 or i_clear=1 at a rising edge, next state SHALL be EMPTY, cnt = 0, and word register and buffer cleared to 0.
REQ-031 The same condition SHALL set o_input_ready=0, o_output_valid=0, o_data=0 and o_last=0; o_accept and o_transmit are then 0.
REQ-032 The first edge after release SHALL set o_input_ready=1.
REQ-033 Clear or reset mid-word SHALL discard the in-flight word and any buffered word; no partial beats afterwards.

Verification (DATA_WIDTH=8, RATIO=4 unless stated)
REQ-034 Reset: i_aresetn low 3 cycles -> all outputs 0; after release o_input_ready=1 and o_output_valid=0.
REQ-035 Single word 0x44332211, i_output_ready=1 -> beats 0x11,0x22,0x33,0x44 on consecutive cycles; o_last only with 0x44; then o_output_valid=0.
REQ-036 Words 0x44332211 then 0x88776655, continuous valid/ready -> 8 beats 0x11..0x88 with no gap; o_input_ready=0 while FULL; o_accept count=2, o_transmit count=8.
REQ-037 Backpressure: i_output_ready=0 for 3 cycles on beat 0x22 -> o_data=0x22 and o_output_valid=1 held; sequence resumes at 0x33.
REQ-038 i_clear=1 in FULL (during beat 0x22, second word buffered) -> next cycle o_output_valid=0 and o_input_ready=0; then o_input_ready=1; no beats of either word appear.
REQ-039 RATIO=3, word 0x332211 -> beats 0x11,0x22,0x33; o_last on 0x33; cnt returns to 0.
